// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants for the platformer level-flow logic. The renderer
// and the top level consume these as well, so the state encodings are fixed
// values and must not be renumbered.
//   game_state_e : 3-bit state encoding (renderer-compatible)
//   TICK_HZ      : game tick rate
//   SPAWN_*_DEF  : default respawn coordinates
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int TICK_HZ = 60;

    localparam logic [9:0] SPAWN_X_DEF  = 10'd20;
    localparam logic [9:0] SPAWN_Y0_DEF = 10'd344;
    localparam logic [9:0] SPAWN_YN_DEF = 10'd364;

    typedef enum logic [2:0] {
        ST_RUNNING   = 3'd0,
        ST_GAME_OVER = 3'd1,
        ST_WIN       = 3'd2,
        ST_TITLE     = 3'd3,
        ST_LOAD      = 3'd4,
        ST_DYING     = 3'd5,
        ST_CLEAR     = 3'd6
    } game_state_e;

endpackage

// File: rtl/tick_down_timer.sv
// ---------------------------------------------------------------------------
// tick_down_timer
// 8-bit down counter that loads on demand and decrements once per game
// tick, holding at zero.
//   clk, rst      : clock, asynchronous active-low reset (count -> 0)
//   tick          : decrement enable (one-clk pulse)
//   load          : load load_val this clk (wins over decrement)
//   load_val[7:0] : value to load
//   count[7:0]    : current count
//   zero          : count == 0
// ---------------------------------------------------------------------------
module tick_down_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       zero
);

    logic [7:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == 8'd0);

endmodule

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
// Level-flow sequencer: TITLE -> LOAD -> RUNNING -> DYING/CLEAR -> ... ->
// GAME_OVER/WIN. Tracks level index and lives, and drives freeze, respawn
// and lava-reset controls for the physics, lava and renderer blocks.
//
// Optional feature macro: GAME_LIVES_EN. When defined, deaths consume lives
// and respawn on the same level until none remain. When undefined, lives
// reads as 1 and every death ends the game.
//
// Ports:
//   clk, rst          : 50 MHz clock, asynchronous active-low reset
//   game_tick         : 60 Hz one-clk pulse; all state updates wait for it
//   start             : start/continue button level
//   in_lava, hit_lava_wall, at_goal_region : collision inputs
//   game_state[2:0]   : current state encoding (game_state_e)
//   level[1:0]        : current level index
//   lives[1:0]        : remaining lives
//   freeze            : halt player physics and lava motion
//   respawn_pulse     : one-clk pulse, load spawn_x/spawn_y into the player
//   lava_reset_pulse  : one-clk pulse, return lava to start positions
//   spawn_x, spawn_y  : respawn coordinates
//
// Handshake note: there is no valid/ready traffic here; the pulses are
// fire-and-forget strobes, high for exactly one clk on the edge where the
// tick that enters LOAD is sampled.
// ---------------------------------------------------------------------------
module game_flow_controller
    import game_pkg::*;
#(
    parameter int         NUM_LEVELS       = 2,
    parameter int         LIVES_INIT       = 3,
    parameter int         DEATH_HOLD_TICKS = 90,
    parameter int         CLEAR_HOLD_TICKS = 120,
    parameter logic [9:0] SPAWN_X          = SPAWN_X_DEF,
    parameter logic [9:0] SPAWN_Y0         = SPAWN_Y0_DEF,
    parameter logic [9:0] SPAWN_YN         = SPAWN_YN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       start,
    input  logic       in_lava,
    input  logic       hit_lava_wall,
    input  logic       at_goal_region,
    output logic [2:0] game_state,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       freeze,
    output logic       respawn_pulse,
    output logic       lava_reset_pulse,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y
);

    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [7:0] DEATH_LOAD = 8'(DEATH_HOLD_TICKS - 1);
    localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_HOLD_TICKS - 1);

    game_state_e state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic        start_q, start_d;
    logic        freeze_q, freeze_d;
    logic        pulse_q, pulse_d;
    logic [9:0]  spawn_y_q, spawn_y_d;
`ifdef GAME_LIVES_EN
    logic [1:0]  lives_q, lives_d;
`endif

    logic        timer_load;
    logic [7:0]  timer_val;
    logic [7:0]  timer_count;
    logic        timer_zero;
    logic        start_edge;
    logic        hazard;

    assign start_edge = start & ~start_q;
    assign hazard     = in_lava | hit_lava_wall;

    // One timer serves both DYING and CLEAR; only one can be active.
    tick_down_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (game_tick),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .zero     (timer_zero)
    );

    // ---------------- state register ----------------
    // start_q resets high so a button held through reset cannot auto-start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_TITLE;
            level_q   <= 2'd0;
            start_q   <= 1'b1;
            freeze_q  <= 1'b1;
            pulse_q   <= 1'b0;
            spawn_y_q <= SPAWN_Y0;
`ifdef GAME_LIVES_EN
            lives_q   <= 2'(LIVES_INIT);
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            start_q   <= start_d;
            freeze_q  <= freeze_d;
            pulse_q   <= pulse_d;
            spawn_y_q <= spawn_y_d;
`ifdef GAME_LIVES_EN
            lives_q   <= lives_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        start_d    = start_q;
        timer_load = 1'b0;
        timer_val  = 8'd0;
`ifdef GAME_LIVES_EN
        lives_d    = lives_q;
`endif
        if (game_tick) begin
            start_d = start;
            case (state_q)
                ST_TITLE: begin
                    if (start_edge) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    // Hazard wins over goal on the same tick.
                    if (hazard) begin
                        state_d    = ST_DYING;
                        timer_load = 1'b1;
                        timer_val  = DEATH_LOAD;
                    end else if (at_goal_region) begin
                        state_d    = ST_CLEAR;
                        timer_load = 1'b1;
                        timer_val  = CLEAR_LOAD;
                    end
                end
                ST_DYING: begin
                    if (timer_zero) begin
`ifdef GAME_LIVES_EN
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            state_d = ST_LOAD;
                        end else begin
                            lives_d = 2'd0;
                            state_d = ST_GAME_OVER;
                        end
`else
                        state_d = ST_GAME_OVER;
`endif
                    end
                end
                ST_CLEAR: begin
                    if (timer_zero) begin
                        if (level_q == LAST_LEVEL) begin
                            state_d = ST_WIN;
                        end else begin
                            level_d = level_q + 2'd1;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    if (start_edge) begin
                        level_d = 2'd0;
`ifdef GAME_LIVES_EN
                        lives_d = 2'(LIVES_INIT);
`endif
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_TITLE;
                end
            endcase
        end
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the post-transition values so they land on
    // the same edge as the state change.
    always_comb begin
        freeze_d  = (state_d != ST_RUNNING);
        pulse_d   = game_tick && (state_d == ST_LOAD) && (state_q != ST_LOAD);
        spawn_y_d = (level_d == 2'd0) ? SPAWN_Y0 : SPAWN_YN;
    end

    assign game_state       = state_q;
    assign level            = level_q;
    assign freeze           = freeze_q;
    assign respawn_pulse    = pulse_q;
    assign lava_reset_pulse = pulse_q;
    assign spawn_x          = SPAWN_X;
    assign spawn_y          = spawn_y_q;
`ifdef GAME_LIVES_EN
    assign lives            = lives_q;
`else
    // Single life; LIVES_INIT is always at least 1 so this reads 1.
    assign lives            = (LIVES_INIT != 0) ? 2'd1 : 2'd0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// ---------------------------------------------------------------------------
// tb_game_flow_controller
// Directed bench for game_flow_controller with default parameters. Honours
// GAME_LIVES_EN when the bundle is built with it.
// ---------------------------------------------------------------------------
module tb_game_flow_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_tick;
    logic       start;
    logic       in_lava;
    logic       hit_lava_wall;
    logic       at_goal_region;
    logic [2:0] game_state;
    logic [1:0] level;
    logic [1:0] lives;
    logic       freeze;
    logic       respawn_pulse;
    logic       lava_reset_pulse;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;

`ifdef GAME_LIVES_EN
    localparam int L0 = 3;
`else
    localparam int L0 = 1;
`endif

    int checks   = 0;
    int failures = 0;

    game_flow_controller dut (
        .clk              (clk),
        .rst              (rst),
        .game_tick        (game_tick),
        .start            (start),
        .in_lava          (in_lava),
        .hit_lava_wall    (hit_lava_wall),
        .at_goal_region   (at_goal_region),
        .game_state       (game_state),
        .level            (level),
        .lives            (lives),
        .freeze           (freeze),
        .respawn_pulse    (respawn_pulse),
        .lava_reset_pulse (lava_reset_pulse),
        .spawn_x          (spawn_x),
        .spawn_y          (spawn_y)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int st, input int lv,
                             input int li, input int fr, input int rp,
                             input int sy);
        check({name, ".state"},   int'(game_state),       st);
        check({name, ".level"},   int'(level),            lv);
        check({name, ".lives"},   int'(lives),            li);
        check({name, ".freeze"},  int'(freeze),           fr);
        check({name, ".respawn"}, int'(respawn_pulse),    rp);
        check({name, ".lavarst"}, int'(lava_reset_pulse), rp);
        check({name, ".spawn_x"}, int'(spawn_x),          20);
        check({name, ".spawn_y"}, int'(spawn_y),          sy);
    endtask

    // ---------------- drivers ----------------
    // One tick: game_tick high for one clk; outputs sampled at the
    // following negedge, one posedge after the tick was seen.
    task automatic do_tick();
        @(negedge clk);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic set_in(input logic s, input logic l, input logic w,
                          input logic g);
        start          = s;
        in_lava        = l;
        hit_lava_wall  = w;
        at_goal_region = g;
    endtask

    // Pulse must be gone one clk after it fired.
    task automatic check_pulse_gone(input string name);
        @(negedge clk);
        check({name, ".pulse_gone"}, int'(respawn_pulse | lava_reset_pulse), 0);
    endtask

    // Hazard tick from RUNNING, DEATH_HOLD ticks in DYING; returns right after
    // the timeout tick.
    task automatic die(input string name, input logic use_wall);
        set_in(1'b0, ~use_wall, use_wall, 1'b0);
        do_tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, ".enter_state"},  int'(game_state), 5);
        check({name, ".enter_freeze"}, int'(freeze),     1);
        for (int i = 0; i < 89; i++) begin
            do_tick();
            check($sformatf("%s.dwell%0d", name, i), int'(game_state), 5);
        end
        do_tick();
    endtask

    task automatic clear_level(input string name, input logic hazard_during);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        set_in(1'b0, hazard_during, 1'b0, 1'b0);
        check({name, ".enter_state"}, int'(game_state), 6);
        for (int i = 0; i < 119; i++) begin
            do_tick();
            check($sformatf("%s.dwell%0d", name, i), int'(game_state), 6);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic s, l, w, g;
        int   st, lv, li, fr, rp, sy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        //            s     l     w     g     st lv li  fr rp sy
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0, L0, 1, 0, 344}; // held start, no edge
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 0, L0, 1, 0, 344};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 0, L0, 1, 1, 344}; // edge -> LOAD
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, L0, 0, 0, 344}; // LOAD ignores hazard
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, L0, 0, 0, 344};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, L0, 0, 0, 344}; // start ignored
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, L0, 0, 0, 344};

        // ---------------- reset ----------------
        rst       = 1'b0;
        game_tick = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_all("reset_held", 3, 0, L0, 1, 0, 344);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all("reset_rel", 3, 0, L0, 1, 0, 344);

        // ---------------- table: title -> load -> running ----------------
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].s, vecs[i].l, vecs[i].w, vecs[i].g);
            do_tick();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv,
                      vecs[i].li, vecs[i].fr, vecs[i].rp, vecs[i].sy);
            if (vecs[i].rp != 0) check_pulse_gone($sformatf("vec%0d", i));
        end

        // Hazard between ticks is invisible.
        @(negedge clk);
        hit_lava_wall = 1'b1;
        @(negedge clk);
        hit_lava_wall = 1'b0;
        do_tick();
        check("between_ticks.state", int'(game_state), 0);

        // ---------------- deaths ----------------
        // Lava and goal together: hazard wins.
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        do_tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check("both.state", int'(game_state), 5);
        for (int i = 0; i < 89; i++) begin
            do_tick();
            check($sformatf("death1.dwell%0d", i), int'(game_state), 5);
        end
        do_tick();
`ifdef GAME_LIVES_EN
        check_all("death1_out", 4, 0, 2, 1, 1, 344);
        check_pulse_gone("death1_out");
        do_tick();
        check("death1_run", int'(game_state), 0);
        die("death2", 1'b1);
        check_all("death2_out", 4, 0, 1, 1, 1, 344);
        do_tick();
        die("death3", 1'b0);
        check_all("death3_out", 1, 0, 0, 1, 0, 344);
`else
        check_all("death1_out", 1, 0, 1, 1, 0, 344);
`endif
        // GAME_OVER holds without a start edge, even with hazards.
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        do_tick();
        check("gameover_hold", int'(game_state), 1);

        // ---------------- restart from GAME_OVER ----------------
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        do_tick();
        check_all("go_restart", 4, 0, L0, 1, 1, 344);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick();
        check_all("go_run", 0, 0, L0, 0, 0, 344);

        // ---------------- level clear and win ----------------
        clear_level("clear0", 1'b0);
        check_all("clear0_out", 4, 1, L0, 1, 1, 364);
        check_pulse_gone("clear0_out");
        do_tick();
        check_all("lvl1_run", 0, 1, L0, 0, 0, 364);
        clear_level("clear1", 1'b1);
        check_all("win", 2, 1, L0, 1, 0, 364);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        check_all("win_hold", 2, 1, L0, 1, 0, 364);

        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        do_tick();
        check_all("win_restart", 4, 0, L0, 1, 1, 344);
        check_pulse_gone("win_restart");
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick();
        check("restart_run", int'(game_state), 0);

        // ---------------- reset mid-DYING ----------------
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        do_tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 49; i++) do_tick();   // timer now 40
        check("mid_dying.state", int'(game_state), 5);
        @(negedge clk);
        start = 1'b1;
        #3 rst = 1'b0;
        #1;
        check_all("async_rst", 3, 0, L0, 1, 0, 344);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all($sformatf("post_rst%0d", i), 3, 0, L0, 1, 0, 344);
        end
        do_tick();
        check("post_rst_held_start", int'(game_state), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
